// File: rtl/alu_pkg.sv
// alu_pkg: shared unit-select codes and issue FSM state encoding
package alu_pkg;
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT = 2'b10} state_t;
endpackage

// File: rtl/alu_op_fifo.sv
// alu_op_fifo: small circular op buffer; a push while full is honoured only alongside a pop
module alu_op_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    // Pointer and occupancy update; pointers wrap naturally at power-of-two depth
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // Control registers; reset empties the buffer by clearing the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
    // Storage needs no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU ops, issues each to one unit, and returns its registered result
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_fun,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       ALU_FUN,
    output logic             Arith_Enable,
    output logic             Logic_Enable,
    output logic             CMP_Enable,
    output logic             Shift_Enable,
    input  logic [WIDTH-1:0] arith_out,
    input  logic [WIDTH-1:0] logic_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    input  logic             arith_flag,
    input  logic             logic_flag,
    input  logic             cmp_flag,
    input  logic             shift_flag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_unit,
    output logic             err
);
    localparam int PW = 2*WIDTH + 4;
    logic [PW-1:0]    head;
    logic             full, empty, push, pop, sel_flag;
    logic [WIDTH-1:0] sel_out;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, out_result_q, out_result_d;
    logic [1:0]       fun_q, fun_d, unit_q, unit_d, out_unit_q, out_unit_d;
    logic [3:0]       en_q, en_d;
    logic             out_valid_q, out_valid_d, err_q, err_d;
    state_t           state_q, state_d;
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE || state_q == WAIT) && !empty;
    alu_op_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b, in_fun}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
    // Route the in-flight unit's result and flag
    always_comb begin
        sel_out  = unit_q == UNIT_ARITH ? arith_out  : unit_q == UNIT_LOGIC ? logic_out  :
                   unit_q == UNIT_CMP   ? cmp_out    : shift_out;
        sel_flag = unit_q == UNIT_ARITH ? arith_flag : unit_q == UNIT_LOGIC ? logic_flag :
                   unit_q == UNIT_CMP   ? cmp_flag   : shift_flag;
    end
    // Next state: pop and load in IDLE/WAIT, one-cycle enable in ISSUE, capture result in WAIT
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        fun_d        = fun_q;
        unit_d       = unit_q;
        en_d         = 4'b0000;
        out_valid_d  = 1'b0;
        out_result_d = out_result_q;
        out_unit_d   = out_unit_q;
        err_d        = err_q;
        case (state_q)
            IDLE:    state_d = empty ? IDLE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                state_d      = empty ? IDLE : ISSUE;
                out_valid_d  = sel_flag;
                out_result_d = sel_flag ? sel_out : out_result_q;
                out_unit_d   = sel_flag ? unit_q : out_unit_q;
                err_d        = err_q || !sel_flag;
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            a_d    = head[PW-1 -: WIDTH];
            b_d    = head[WIDTH+3 -: WIDTH];
            fun_d  = head[1:0];
            unit_d = head[3:2];
            en_d   = 4'b0001 << head[3:2];
        end
    end
    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            fun_q        <= '0;
            unit_q       <= '0;
            en_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_unit_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            fun_q        <= fun_d;
            unit_q       <= unit_d;
            en_q         <= en_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_unit_q   <= out_unit_d;
            err_q        <= err_d;
        end
    end
    assign A            = a_q;
    assign B            = b_q;
    assign ALU_FUN      = fun_q;
    assign Arith_Enable = en_q[0];
    assign Logic_Enable = en_q[1];
    assign CMP_Enable   = en_q[2];
    assign Shift_Enable = en_q[3];
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_unit     = out_unit_q;
    assign err          = err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with registered unit models for alu_issue_ctrl
module tb_alu_issue_ctrl;
    import alu_pkg::*;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_a = '0, in_b = '0;
    logic [3:0]  in_fun = '0;
    logic [15:0] A, B, out_result;
    logic [1:0]  ALU_FUN, out_unit;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
    logic [15:0] arith_out, logic_out, cmp_out, shift_out;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic        out_valid, err;
    int          n_run = 0, n_fail = 0, cyc = 0, en_viol = 0;
    bit          shift_ok = 1'b1;
    logic [17:0] sb[$];
    int          pulse_t[$];
    logic [17:0] exp_v;

    alu_issue_ctrl #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_fun(in_fun), .A(A), .B(B), .ALU_FUN(ALU_FUN),
        .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
        .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .out_valid(out_valid), .out_result(out_result), .out_unit(out_unit), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        logic [15:0] r;
        case (f)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a + 16'd1;
            4'b0011: r = a - 16'd1;
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a & b);
            4'b1000: r = 16'd0;
            4'b1001: r = (a == b) ? 16'd1 : 16'd0;
            4'b1010: r = (a > b) ? 16'd2 : 16'd0;
            4'b1011: r = (a < b) ? 16'd3 : 16'd0;
            4'b1100: r = a << b[3:0];
            4'b1101: r = a >> b[3:0];
            4'b1110: r = $signed(a) >>> b[3:0];
            default: r = {a[14:0], a[15]};
        endcase
        return r;
    endfunction

    // Registered execution units: result and flag appear the cycle after their enable
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            {arith_flag, logic_flag, cmp_flag, shift_flag} <= '0;
            {arith_out, logic_out, cmp_out, shift_out} <= '0;
        end else begin
            arith_flag <= Arith_Enable;
            logic_flag <= Logic_Enable;
            cmp_flag   <= CMP_Enable;
            shift_flag <= Shift_Enable && shift_ok;
            arith_out  <= model(A, B, {UNIT_ARITH, ALU_FUN});
            logic_out  <= model(A, B, {UNIT_LOGIC, ALU_FUN});
            cmp_out    <= model(A, B, {UNIT_CMP, ALU_FUN});
            shift_out  <= model(A, B, {UNIT_SHIFT, ALU_FUN});
        end
    end

    // Scoreboard: every result pulse must match the oldest expected op
    always @(negedge clk) begin
        if (rst) begin
            if ($countones({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable}) > 1) en_viol++;
            if (out_valid) begin
                pulse_t.push_back(cyc);
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got result=%h unit=%0d, required no pulse", out_result, out_unit);
                end else begin
                    exp_v = sb.pop_front();
                    if ({out_result, out_unit} !== exp_v) begin
                        n_fail++;
                        $display("FAIL result: got result=%h unit=%0d, required result=%h unit=%0d",
                                 out_result, out_unit, exp_v[17:2], exp_v[1:0]);
                    end
                end
            end
        end
    end

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                           input bit expect_res, output int waited);
        int g = 0;
        bit rdy;
        in_valid = 1'b1; in_a = a; in_b = b; in_fun = f;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            g++;
        end while (!rdy && g < 100);
        waited = g - 1;
        if (!rdy) begin
            n_run++; n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0, required 1 within 100 cycles");
        end else if (expect_res) sb.push_back({model(a, b, f), f[3:2]});
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 80 && sb.size() > 0; i++) begin @(posedge clk); #1; end
        repeat (4) begin @(posedge clk); #1; end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        go_idle();
        rst = 1'b0;
        #3;
        n_run++;
        if ({A, B, ALU_FUN, out_result, out_unit} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got A=%h B=%h fun=%0d res=%h unit=%0d, required all 0", A, B, ALU_FUN, out_result, out_unit);
        end
        n_run++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, out_valid, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en/valid/err=%b, required 000000",
                     {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, out_valid, err});
        end
        n_run++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1", in_ready);
        end
        sb.delete();
        shift_ok = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_single_cmp();
        int w, en_cnt = 0, en_k = -1, v_k = -1, v_cnt = 0;
        logic [15:0] ea = 'x, eb = 'x;
        logic [1:0]  ef = 'x;
        push_op(16'd5, 16'd5, 4'b1001, 1'b1, w);
        go_idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (CMP_Enable) begin en_cnt++; en_k = k; ea = A; eb = B; ef = ALU_FUN; end
            if (out_valid) begin v_cnt++; if (v_k < 0) v_k = k; end
        end
        @(posedge clk); #1;
        n_run++;
        if (en_cnt !== 1 || en_k !== 1) begin
            n_fail++;
            $display("FAIL cmp_enable: got %0d high cycles first at %0d, required 1 at 1", en_cnt, en_k);
        end
        n_run++;
        if ({ea, eb, ef} !== {16'd5, 16'd5, 2'b01}) begin
            n_fail++;
            $display("FAIL cmp_operands: got A=%h B=%h fun=%0d, required 5 5 1", ea, eb, ef);
        end
        n_run++;
        if (v_k !== 3 || v_cnt !== 1) begin
            n_fail++;
            $display("FAIL cmp_latency: got %0d pulses first at %0d, required 1 at 3", v_cnt, v_k);
        end
        n_run++;
        if (err !== 1'b0 || out_unit !== UNIT_CMP) begin
            n_fail++;
            $display("FAIL cmp_status: got err=%b unit=%0d, required 0 2", err, out_unit);
        end
    endtask

    task automatic test_back_to_back();
        int w, stalls = 0;
        pulse_t.delete();
        en_viol = 0;
        push_op(16'd100, 16'd30, 4'b0001, 1'b1, w);    stalls += w;
        push_op(16'h00ff, 16'h0f0f, 4'b0110, 1'b1, w); stalls += w;
        push_op(16'd7, 16'd3, 4'b1010, 1'b1, w);       stalls += w;
        push_op(16'd3, 16'd4, 4'b1100, 1'b1, w);       stalls += w;
        go_idle();
        wait_drain();
        n_run++;
        if (stalls !== 0) begin
            n_fail++;
            $display("FAIL b2b_ready: got %0d stall cycles, required 0", stalls);
        end
        n_run++;
        if (pulse_t.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, required 4", pulse_t.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_run++;
                if (pulse_t[i] - pulse_t[i-1] !== 2) begin
                    n_fail++;
                    $display("FAIL b2b_spacing: got gap %0d, required 2", pulse_t[i] - pulse_t[i-1]);
                end
            end
        end
        n_run++;
        if (en_viol !== 0) begin
            n_fail++;
            $display("FAIL b2b_onehot: got %0d overlapping-enable cycles, required 0", en_viol);
        end
        n_run++;
        if ({A, B, ALU_FUN} !== {16'd3, 16'd4, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_hold: got A=%h B=%h fun=%0d, required 3 4 0", A, B, ALU_FUN);
        end
    endtask

    task automatic test_fifo_full();
        int w;
        int waits[10];
        for (int i = 0; i < 10; i++) begin
            push_op(16'(i * 37 + 11), 16'(i * 5 + 2), 4'(i % 4), 1'b1, w);
            waits[i] = w;
        end
        go_idle();
        wait_drain();
        for (int i = 0; i < 10; i++) begin
            n_run++;
            if (waits[i] !== (i < 7 ? 0 : 1)) begin
                n_fail++;
                $display("FAIL full_stall op%0d: got %0d wait cycles, required %0d", i, waits[i], (i < 7 ? 0 : 1));
            end
        end
    endtask

    task automatic test_unused_subfun();
        int w;
        pulse_t.delete();
        push_op(16'h1234, 16'h1234, 4'b1000, 1'b1, w);
        go_idle();
        wait_drain();
        n_run++;
        if (pulse_t.size() !== 1 || out_result !== 16'd0) begin
            n_fail++;
            $display("FAIL unused_subfun: got %0d pulses result=%h, required 1 and 0", pulse_t.size(), out_result);
        end
    endtask

    task automatic test_missing_flag();
        int w;
        pulse_t.delete();
        n_run++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pre: got %b, required 0", err);
        end
        shift_ok = 1'b0;
        push_op(16'h0f00, 16'd4, 4'b1101, 1'b0, w);
        push_op(16'd7, 16'd3, 4'b1010, 1'b1, w);
        go_idle();
        wait_drain();
        shift_ok = 1'b1;
        n_run++;
        if (err !== 1'b1 || pulse_t.size() !== 1) begin
            n_fail++;
            $display("FAIL missing_flag: got err=%b pulses=%0d, required err=1 pulses=1", err, pulse_t.size());
        end
        push_op(16'd9, 16'd4, 4'b0000, 1'b1, w);
        go_idle();
        wait_drain();
        n_run++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
    endtask

    task automatic test_reset_midop();
        int w, bad = 0;
        bit saw_en = 1'b0;
        for (int i = 0; i < 6; i++) push_op(16'(i + 20), 16'd1, 4'b0000, 1'b1, w);
        go_idle();
        @(negedge clk);
        saw_en = Arith_Enable;
        n_run++;
        if (saw_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_issue: got Arith_Enable=%b, required 1", saw_en);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        n_run++;
        if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, out_valid, in_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL midop_reset: got en/valid/ready=%b, required 000001",
                     {Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, out_valid, in_ready});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if ({Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable, out_valid} !== 5'b0 || in_ready !== 1'b1) bad++;
        end
        @(posedge clk); #1;
        n_run++;
        if (bad !== 0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_after: got %0d active cycles err=%b, required 0 and 0", bad, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_cmp();
        test_back_to_back();
        test_fifo_full();
        test_unused_subfun();
        test_missing_flag();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
